// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: status codes, bubble field values and status derivation.
package y86_pkg;

  localparam logic [3:0] StatAok = 4'd1;
  localparam logic [3:0] StatHlt = 4'd2;
  localparam logic [3:0] StatAdr = 4'd3;
  localparam logic [3:0] StatIns = 4'd4;

  localparam logic [3:0] IcodeNop = 4'h1;
  localparam logic [3:0] RegNone  = 4'hF;

  localparam logic [3:0] BubbleIcode = IcodeNop;
  localparam logic [3:0] BubbleIfun  = 4'h0;
  localparam logic [3:0] BubbleRid   = RegNone;
  localparam logic [3:0] BubbleStat  = StatAok;

  // Per-edge action of a stage register once reset has been ruled out
  typedef enum logic [1:0] {
    UpdHold,
    UpdBubble,
    UpdLoad
  } upd_e;

  // Local exceptions override the upstream status, most severe first
  function automatic logic [3:0] derive_stat(input logic       hlt,
                                             input logic       imem_err,
                                             input logic       instr_invalid,
                                             input logic [3:0] in_stat);
    logic [3:0] stat;
    if (hlt) begin
      stat = StatHlt;
    end else if (imem_err) begin
      stat = StatAdr;
    end else if (instr_invalid) begin
      stat = StatIns;
    end else begin
      stat = in_stat;
    end
    return stat;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_reg.sv
// Generic Y86 pipeline stage register with stall/bubble control, exception freeze and
// saturating stall/bubble event counters.
module pipe_reg
  import y86_pkg::*;
#(
  parameter int unsigned VAL_W         = 64,
  parameter int unsigned NUM_VAL       = 2,
  parameter int unsigned NUM_RID       = 2,
  parameter int unsigned CNT_W         = 16,
  parameter bit          FREEZE_ON_EXC = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     bubble,
  input  logic [3:0]               in_icode,
  input  logic [3:0]               in_ifun,
  input  logic [4*NUM_RID-1:0]     in_rid,
  input  logic [VAL_W*NUM_VAL-1:0] in_val,
  input  logic [3:0]               in_stat,
  input  logic                     hlt,
  input  logic                     imem_err,
  input  logic                     instr_invalid,
  output logic [3:0]               out_icode,
  output logic [3:0]               out_ifun,
  output logic [4*NUM_RID-1:0]     out_rid,
  output logic [VAL_W*NUM_VAL-1:0] out_val,
  output logic [3:0]               out_stat,
  output logic                     frozen,
  output logic                     conflict,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  upd_e                     upd;
  logic [3:0]               load_stat;
  logic                     stall_inc, bubble_inc;

  logic [3:0]               icode_d, icode_q;
  logic [3:0]               ifun_d, ifun_q;
  logic [4*NUM_RID-1:0]     rid_d, rid_q;
  logic [VAL_W*NUM_VAL-1:0] val_d, val_q;
  logic [3:0]               stat_d, stat_q;
  logic                     frozen_d, frozen_q;
  logic                     conflict_d, conflict_q;

  assign load_stat = derive_stat(hlt, imem_err, instr_invalid, in_stat);

  // A frozen register ignores stall and bubble entirely, including for event counting
  always_comb begin
    upd        = UpdLoad;
    stall_inc  = 1'b0;
    bubble_inc = 1'b0;
    if (frozen_q) begin
      upd = UpdHold;
    end else if (stall) begin
      upd       = UpdHold;
      stall_inc = 1'b1;
    end else if (bubble) begin
      upd        = UpdBubble;
      bubble_inc = 1'b1;
    end
  end

  assign conflict_d = stall & bubble & ~frozen_q;

  always_comb begin
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    rid_d    = rid_q;
    val_d    = val_q;
    stat_d   = stat_q;
    frozen_d = frozen_q;
    unique case (upd)
      UpdHold: begin
      end
      UpdBubble: begin
        icode_d = BubbleIcode;
        ifun_d  = BubbleIfun;
        rid_d   = {NUM_RID{BubbleRid}};
        val_d   = '0;
        stat_d  = BubbleStat;
      end
      UpdLoad: begin
        icode_d = in_icode;
        ifun_d  = in_ifun;
        rid_d   = in_rid;
        val_d   = in_val;
        stat_d  = load_stat;
        if (FREEZE_ON_EXC && (load_stat != StatAok)) begin
          frozen_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      icode_q    <= BubbleIcode;
      ifun_q     <= BubbleIfun;
      rid_q      <= {NUM_RID{BubbleRid}};
      val_q      <= '0;
      stat_q     <= BubbleStat;
      frozen_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      icode_q    <= icode_d;
      ifun_q     <= ifun_d;
      rid_q      <= rid_d;
      val_q      <= val_d;
      stat_q     <= stat_d;
      frozen_q   <= frozen_d;
      conflict_q <= conflict_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (bubble_inc),
    .count(bubble_cnt)
  );

  assign out_icode = icode_q;
  assign out_ifun  = ifun_q;
  assign out_rid   = rid_q;
  assign out_val   = val_q;
  assign out_stat  = stat_q;
  assign frozen    = frozen_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg: a default instance and a CNT_W=2, no-freeze instance
// share stimulus; each expected entry names the instance it checks.
module tb_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, stall, bubble, hlt, imem_err, instr_invalid;
  logic [3:0]   in_icode, in_ifun, in_stat;
  logic [7:0]   in_rid;
  logic [127:0] in_val;

  logic [3:0]   a_icode, a_ifun, a_stat, b_icode, b_ifun, b_stat;
  logic [7:0]   a_rid, b_rid;
  logic [127:0] a_val, b_val;
  logic         a_frozen, a_conflict, b_frozen, b_conflict;
  logic [15:0]  a_sc, a_bc;
  logic [1:0]   b_sc, b_bc;

  pipe_reg dut_a (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .bubble       (bubble),
    .in_icode     (in_icode),
    .in_ifun      (in_ifun),
    .in_rid       (in_rid),
    .in_val       (in_val),
    .in_stat      (in_stat),
    .hlt          (hlt),
    .imem_err     (imem_err),
    .instr_invalid(instr_invalid),
    .out_icode    (a_icode),
    .out_ifun     (a_ifun),
    .out_rid      (a_rid),
    .out_val      (a_val),
    .out_stat     (a_stat),
    .frozen       (a_frozen),
    .conflict     (a_conflict),
    .stall_cnt    (a_sc),
    .bubble_cnt   (a_bc)
  );

  pipe_reg #(
    .CNT_W        (2),
    .FREEZE_ON_EXC(1'b0)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .bubble       (bubble),
    .in_icode     (in_icode),
    .in_ifun      (in_ifun),
    .in_rid       (in_rid),
    .in_val       (in_val),
    .in_stat      (in_stat),
    .hlt          (hlt),
    .imem_err     (imem_err),
    .instr_invalid(instr_invalid),
    .out_icode    (b_icode),
    .out_ifun     (b_ifun),
    .out_rid      (b_rid),
    .out_val      (b_val),
    .out_stat     (b_stat),
    .frozen       (b_frozen),
    .conflict     (b_conflict),
    .stall_cnt    (b_sc),
    .bubble_cnt   (b_bc)
  );

  typedef struct {
    int           step;
    bit           sel;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [7:0]   rid;
    logic [127:0] val;
    logic [3:0]   stat;
    logic         frozen;
    logic         conflict;
    logic [15:0]  sc;
    logic [15:0]  bc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   step  = 0;

  task automatic check(input int s, input string name, input logic [127:0] got,
                       input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL step %0d %s: got %0h expected %0h", s, name, got, want);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [3:0] ic,
                       input logic [3:0] ifn, input logic [7:0] rid, input logic [127:0] v,
                       input logic [3:0] st, input logic [2:0] exc);
    @(negedge clk);
    reset    = r;
    stall    = s;
    bubble   = b;
    in_icode = ic;
    in_ifun  = ifn;
    in_rid   = rid;
    in_val   = v;
    in_stat  = st;
    {hlt, imem_err, instr_invalid} = exc;
  endtask

  task automatic expect_out(input bit sel, input logic [3:0] ic, input logic [3:0] ifn,
                            input logic [7:0] rid, input logic [127:0] v,
                            input logic [3:0] st, input logic frz, input logic cfl,
                            input logic [15:0] sc, input logic [15:0] bc);
    exp_t e;
    step++;
    e.step = step; e.sel = sel; e.icode = ic; e.ifun = ifn; e.rid = rid; e.val = v;
    e.stat = st; e.frozen = frz; e.conflict = cfl; e.sc = sc; e.bc = bc;
    exp_q.push_back(e);
  endtask

  // Monitor: the register presents new contents after every posedge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!e.sel) begin
          check(e.step, "A icode", 128'(a_icode), 128'(e.icode));
          check(e.step, "A ifun", 128'(a_ifun), 128'(e.ifun));
          check(e.step, "A rid", 128'(a_rid), 128'(e.rid));
          check(e.step, "A val", a_val, e.val);
          check(e.step, "A stat", 128'(a_stat), 128'(e.stat));
          check(e.step, "A frozen", 128'(a_frozen), 128'(e.frozen));
          check(e.step, "A conflict", 128'(a_conflict), 128'(e.conflict));
          check(e.step, "A stall_cnt", 128'(a_sc), 128'(e.sc));
          check(e.step, "A bubble_cnt", 128'(a_bc), 128'(e.bc));
        end else begin
          check(e.step, "B icode", 128'(b_icode), 128'(e.icode));
          check(e.step, "B ifun", 128'(b_ifun), 128'(e.ifun));
          check(e.step, "B rid", 128'(b_rid), 128'(e.rid));
          check(e.step, "B val", b_val, e.val);
          check(e.step, "B stat", 128'(b_stat), 128'(e.stat));
          check(e.step, "B frozen", 128'(b_frozen), 128'(e.frozen));
          check(e.step, "B conflict", 128'(b_conflict), 128'(e.conflict));
          check(e.step, "B stall_cnt", 128'(b_sc), 128'(e.sc));
          check(e.step, "B bubble_cnt", 128'(b_bc), 128'(e.bc));
        end
      end
    end
  end

  localparam logic [127:0] V1234 = 128'h1234;
  localparam logic [127:0] VDead = 128'hdead;

  initial begin
    logic [15:0] bc;
    reset = 1'b1; stall = 1'b0; bubble = 1'b0; hlt = 1'b0; imem_err = 1'b0;
    instr_invalid = 1'b0; in_icode = 4'h0; in_ifun = 4'h0; in_rid = 8'h00;
    in_val = '0; in_stat = 4'h1;

    // Reset, then idle with bubble-like inputs
    drive(1, 0, 0, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 3'b000);
    expect_out(0, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 0, 0, 16'd0, 16'd0);
    drive(0, 0, 0, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 3'b000);
    expect_out(0, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 0, 0, 16'd0, 16'd0);

    // Load valC=0x1234, then stall three cycles against changing inputs
    drive(0, 0, 0, 4'h6, 4'h0, 8'h23, V1234, 4'h1, 3'b000);
    expect_out(0, 4'h6, 4'h0, 8'h23, V1234, 4'h1, 0, 0, 16'd0, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 0, 4'h7, 4'h2, 8'h99, VDead, 4'h4, 3'b100);
      expect_out(0, 4'h6, 4'h0, 8'h23, V1234, 4'h1, 0, 0, 16'(i), 16'd0);
    end

    // Stall+bubble together acts as stall; conflict visible for one cycle only
    drive(0, 1, 1, 4'h7, 4'h2, 8'h99, VDead, 4'h1, 3'b000);
    expect_out(0, 4'h6, 4'h0, 8'h23, V1234, 4'h1, 0, 1, 16'd4, 16'd0);
    drive(0, 0, 1, 4'h7, 4'h2, 8'h99, VDead, 4'h4, 3'b100);
    expect_out(0, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 0, 0, 16'd4, 16'd1);
    drive(0, 0, 0, 4'h2, 4'h1, 8'h45, {64'haaaa, 64'h5555}, 4'h1, 3'b000);
    expect_out(0, 4'h2, 4'h1, 8'h45, {64'haaaa, 64'h5555}, 4'h1, 0, 0, 16'd4, 16'd1);

    // imem_err beats instr_invalid -> ADR and freeze; later loads/bubble/stall ignored
    drive(0, 0, 0, 4'h3, 4'h0, 8'h67, {64'h11, 64'h22}, 4'h1, 3'b011);
    expect_out(0, 4'h3, 4'h0, 8'h67, {64'h11, 64'h22}, 4'h3, 1, 0, 16'd4, 16'd1);
    drive(0, 0, 0, 4'h5, 4'h5, 8'hAB, {64'hcc, 64'hdd}, 4'h1, 3'b000);
    expect_out(0, 4'h3, 4'h0, 8'h67, {64'h11, 64'h22}, 4'h3, 1, 0, 16'd4, 16'd1);
    drive(0, 0, 1, 4'h5, 4'h5, 8'hAB, {64'hcc, 64'hdd}, 4'h1, 3'b000);
    expect_out(0, 4'h3, 4'h0, 8'h67, {64'h11, 64'h22}, 4'h3, 1, 0, 16'd4, 16'd1);
    drive(0, 1, 0, 4'h5, 4'h5, 8'hAB, {64'hcc, 64'hdd}, 4'h1, 3'b000);
    expect_out(0, 4'h3, 4'h0, 8'h67, {64'h11, 64'h22}, 4'h3, 1, 0, 16'd4, 16'd1);

    // Reset overrides freeze, stall and bubble at once
    drive(1, 1, 1, 4'h5, 4'h5, 8'hAB, {64'hcc, 64'hdd}, 4'h1, 3'b111);
    expect_out(0, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 0, 0, 16'd0, 16'd0);

    // hlt beats imem_err; upstream non-AOK status also freezes
    drive(0, 0, 0, 4'h0, 4'h0, 8'h01, 128'h1, 4'h1, 3'b110);
    expect_out(0, 4'h0, 4'h0, 8'h01, 128'h1, 4'h2, 1, 0, 16'd0, 16'd0);
    drive(1, 0, 0, 4'h0, 4'h0, 8'h01, 128'h1, 4'h1, 3'b000);
    expect_out(0, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 0, 0, 16'd0, 16'd0);
    drive(0, 0, 0, 4'h8, 4'h3, 8'h5A, 128'h7, 4'h3, 3'b000);
    expect_out(0, 4'h8, 4'h3, 8'h5A, 128'h7, 4'h3, 1, 0, 16'd0, 16'd0);

    // Instance B: CNT_W=2 saturation under a held bubble
    drive(1, 0, 0, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 3'b000);
    expect_out(1, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 0, 0, 16'd0, 16'd0);
    for (int i = 0; i < 6; i++) begin
      bc = (i < 3) ? 16'(i + 1) : 16'd3;
      drive(0, 0, 1, 4'h6, 4'h0, 8'h23, V1234, 4'h1, 3'b000);
      expect_out(1, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 0, 0, 16'd0, bc);
    end

    // Instance B: no freeze, exceptions still reported
    drive(0, 0, 0, 4'h0, 4'h0, 8'h12, 128'h5, 4'h1, 3'b100);
    expect_out(1, 4'h0, 4'h0, 8'h12, 128'h5, 4'h2, 0, 0, 16'd0, 16'd3);
    drive(0, 0, 0, 4'h6, 4'h0, 8'h34, 128'h7, 4'h1, 3'b000);
    expect_out(1, 4'h6, 4'h0, 8'h34, 128'h7, 4'h1, 0, 0, 16'd0, 16'd3);
    drive(0, 0, 0, 4'hC, 4'h0, 8'h56, 128'h9, 4'h1, 3'b001);
    expect_out(1, 4'hC, 4'h0, 8'h56, 128'h9, 4'h4, 0, 0, 16'd0, 16'd3);
    drive(0, 0, 0, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 3'b000);
    expect_out(1, 4'h1, 4'h0, 8'hFF, '0, 4'h1, 0, 0, 16'd0, 16'd3);

    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter VAL_W, default 64: width of each value field (valC/valP/valE/valM class).
REQ-002 Parameter NUM_VAL, default 2: number of value fields carried.
REQ-003 Parameter NUM_RID, default 2: number of 4-bit register-ID fields carried.
REQ-004 Parameter CNT_W, default 16: width of the stall and bubble event counters.
REQ-005 Parameter FREEZE_ON_EXC, default 1: 1 means the register freezes after latching a non-AOK status; 0 means no freeze.
REQ-006 clk  in  1  single clock; all state updates on posedge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 stall  in  1  hold current contents.
REQ-009 bubble  in  1  load NOP bubble.
REQ-010 in_icode, in_ifun  in  4 each  upstream instruction code/function.
REQ-011 in_rid  in  4*NUM_RID  packed register IDs; field 0 in the LSBs.
REQ-012 in_val  in  VAL_W*NUM_VAL  packed values; field 0 in the LSBs.
REQ-013 in_stat  in  4  upstream status.
REQ-014 hlt, imem_err, instr_invalid  in  1 each  local exception sources.
REQ-015 out_icode, out_ifun, out_rid, out_val, out_stat  out  widths matching the inputs  registered stage contents.
REQ-016 frozen  out  1  register locked on an exception.
REQ-017 conflict  out  1  registered one-cycle pulse: stall and bubble were both asserted in the previous cycle.
REQ-018 stall_cnt, bubble_cnt  out  CNT_W  saturating event counters.

Function
REQ-019 Status codes SHALL be: AOK=1, HLT=2, ADR=3, INS=4.
REQ-020 The bubble contents SHALL be:
- icode=1 (NOP), ifun=0
- every rid field = 4'hF (RNONE)
- every val field = 0
- stat = AOK
REQ-021 The bubble SHALL overwrite ALL output fields, not only icode/ifun.
REQ-022 Update priority per posedge SHALL be, highest first: reset, frozen, stall, bubble, load.
REQ-023 Frozen SHALL hold all outputs; counters SHALL not increment; stall and bubble SHALL be ignored.
REQ-024 Stall SHALL hold all outputs; stall_cnt SHALL increment by 1.
REQ-025 Bubble without stall SHALL load the bubble contents; bubble_cnt SHALL increment by 1.
REQ-026 Load SHALL copy all input fields with out_stat derived by priority: hlt -> HLT, else imem_err -> ADR, else instr_invalid -> INS, else in_stat.
REQ-027 stall and bubble asserted together SHALL be treated as stall (stall_cnt increments, bubble_cnt does not), and conflict SHALL be 1 in the following cycle; otherwise conflict SHALL be 0.
REQ-028 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 With FREEZE_ON_EXC=1, a load whose derived status is not AOK SHALL set frozen in the same posedge that latches that status.
REQ-030 Only reset SHALL clear frozen.
REQ-031 With FREEZE_ON_EXC=0, frozen SHALL stay 0 permanently.
REQ-032 A bubble SHALL never set frozen.
REQ-033 Latency SHALL be one cycle from input to output on load; outputs SHALL be purely registered, with no combinational input-to-output path.

Reset
REQ-034 On reset=1 at posedge, outputs SHALL take the bubble contents, frozen=0, conflict=0, stall_cnt=0, bubble_cnt=0.
REQ-035 Reset SHALL override stall, bubble and frozen in the same cycle.
REQ-036 Reset asserted mid-freeze or mid-stall SHALL return the block to bubble state in one cycle.

Structure
REQ-037 Status codes, NOP icode, RNONE and the bubble field values SHALL live in the shared pipeline package (y86_pkg) for use by all stage registers.
REQ-038 The saturating counter SHALL be one sub-module, sat_counter (parameter CNT_W; inputs clk, reset, inc), instantiated twice.
REQ-039 The block SHALL serve as the D/E/M/W stage register by parameter choice only.

Verification
REQ-040 Reset then idle -> out_icode=1, out_stat=1, all rid=F, all val=0, counters 0, frozen=0.
REQ-041 Load icode=6, valC=0x1234, stat=1, no exceptions, then stall 3 cycles -> outputs hold 0x1234 for 3 cycles, stall_cnt=3.
REQ-042 Load with imem_err=1 and instr_invalid=1 -> out_stat=3, frozen=1; subsequent loads of any data -> outputs unchanged; reset -> bubble state.
REQ-043 stall=1 and bubble=1 in the same cycle -> outputs held, stall_cnt+1, bubble_cnt unchanged, conflict=1 in the next cycle only.
REQ-044 CNT_W=2, bubble held 6 cycles -> bubble_cnt reads 1,2,3,3,3,3; every bubble cycle shows the full bubble contents.
REQ-045 FREEZE_ON_EXC=0, load with hlt=1 -> out_stat=2, frozen=0; next load with stat=1 -> out_stat=1.
